regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-side arbiter for the MIPS register file. Merges two result sources into the register file's single write port (`wr`/`rw`/`d`/`jal`): the in-order pipeline writeback, which has priority and no backpressure, and a long-latency unit (mult/div, cache-miss load), which is buffered in a small FIFO. It also keeps a pending-register scoreboard that the decode stage checks against its two read addresses to generate a stall.

## Interface
Parameters:
- DATA_WIDTH, 32, register data width
- REG_DEPTH, 32, number of architectural registers
- ADDR_WIDTH, 5, register address width (log2 of REG_DEPTH)
- FIFO_DEPTH, 4, long-latency result buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 8, cycles the FIFO head may wait before `drain_req`

Ports:
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- pipe_valid  in  1  pipeline result valid this cycle; always accepted
- pipe_jal  in  1  pipeline result is a JAL link; destination forced to REG_DEPTH-1
- pipe_rw  in  ADDR_WIDTH  pipeline destination register (ignored when pipe_jal=1)
- pipe_d  in  DATA_WIDTH  pipeline result or link value
- long_valid  in  1  long-latency result offered
- long_ready  out  1  FIFO can accept
- long_rw  in  ADDR_WIDTH  long-latency destination register
- long_d  in  DATA_WIDTH  long-latency result
- issue_valid  in  1  a long-latency op is issuing
- issue_rw  in  ADDR_WIDTH  destination of the issuing op
- chk_rr  in  2*ADDR_WIDTH  decode read addresses; [ADDR_WIDTH-1:0] is port 0
- stall  out  1  a read address in chk_rr is pending
- drain_req  out  1  request one pipeline bubble so the FIFO can drain
- wr  out  1  register file write enable
- jal  out  1  register file jal qualifier
- rw  out  ADDR_WIDTH  register file write address
- d  out  DATA_WIDTH  register file write data
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy

## Operation
- Each cycle exactly one source is selected:
  - `pipe_valid=1`: the pipeline result is selected.
  - Otherwise, if the FIFO is non-empty: the FIFO head is selected and popped.
  - Otherwise: no write.
- Selection is registered into `wr`/`jal`/`rw`/`d`.
  - `jal` output = 1 only when the selected result is a pipeline result with `pipe_jal=1`; `rw` is then REG_DEPTH-1.
- Destination 0:
  - `wr` stays 0 for any destination 0 (`rw` and `d` are still driven).
  - A FIFO entry with destination 0 is still popped.
- FIFO push:
  - `long_ready = (fifo_count < FIFO_DEPTH) && !rst`.
  - A push occurs when `long_valid && long_ready`.
  - `long_ready` does not depend on a same-cycle pop, so a full FIFO never accepts even while popping.
  - Push and pop in the same cycle leave the count unchanged.
- Scoreboard (one pending bit per register, bit 0 tied to 0):
  - Set at the edge when `issue_valid` and `issue_rw != 0`.
  - Cleared at the edge where a FIFO pop for that register is written out.
  - If set and clear hit the same register in the same cycle, set wins.
  - Pipeline writes never touch the scoreboard.
- `stall = pending[chk_rr port0] | pending[chk_rr port1]`. It is combinational from current state, with no bypass of same-cycle set or clear.
- Starvation counter:
  - Counts cycles in which the FIFO is non-empty and `pipe_valid=1`.
  - Resets to 0 on every pop, and when the FIFO is empty.
  - `drain_req = (counter >= STARVE_LIMIT)`, registered. It holds until the next pop.
  - The counter saturates at STARVE_LIMIT.

## Timing
- Reset values: `wr=0`, `jal=0`, `rw=0`, `d=0`, `drain_req=0`, `fifo_count=0`, all pending bits 0, starvation counter 0. `long_ready=0` while `rst=1`, and 1 in the first cycle after.
- Reset during operation discards FIFO contents and pending bits at that edge. Inputs sampled while `rst=1` have no effect.
- Pipeline latency: `pipe_valid` in cycle N gives `wr` in cycle N+1.
- Long-latency latency: a push at the edge ending cycle N makes the entry eligible in cycle N+1. With no pipeline traffic, `wr` asserts in cycle N+2, and the pending bit reads clear in cycle N+2.
- At most one write per cycle.
- The FIFO is strictly in order.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst` for 2 cycles, then release.
  - Required: all outputs 0; `long_ready=1` in cycle 1 after release; `fifo_count=0`.
- Pipeline JAL:
  - Stimulus: `pipe_valid=1`, `pipe_jal=1`, `pipe_rw=7`, `pipe_d=0x00400010`.
  - Required: next cycle `wr=1`, `jal=1`, `rw=31`, `d=0x00400010`.
- Scoreboard lifecycle:
  - Stimulus: issue `rw=5`, hold `chk_rr={5,3}`; 3 cycles later push `long_rw=5`, `d=0xDEAD`; no pipeline traffic.
  - Required: `stall=1` from the cycle after issue; `wr` with `rw=5`, `d=0xDEAD` two cycles after the push; `stall=0` that same cycle.
- Priority and full FIFO:
  - Stimulus: hold `pipe_valid=1` continuously, push 5 long results.
  - Required: 4 accepted; `long_ready=0` with `fifo_count=4`; the 5th is held off; only pipeline writes appear.
- Starvation:
  - Stimulus: continue the full-FIFO case with the default STARVE_LIMIT=8.
  - Required: `drain_req=1` after 8 non-empty/pipeline cycles; drop `pipe_valid` for 1 cycle, giving one FIFO pop and `drain_req=0` the following cycle.
- Edge cases:
  - Issue `rw=0` → never pending.
  - Push `long_rw=0` → popped with `wr=0`.
  - Issue and pop-clear of `rw=9` in the same cycle → pending[9] stays 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: pipeline writeback has priority,
// long-latency results are buffered in a FIFO, with a pending-register scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_DEPTH    = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pipe_valid,
  input  logic                            pipe_jal,
  input  logic [ADDR_WIDTH-1:0]           pipe_rw,
  input  logic [DATA_WIDTH-1:0]           pipe_d,
  input  logic                            long_valid,
  output logic                            long_ready,
  input  logic [ADDR_WIDTH-1:0]           long_rw,
  input  logic [DATA_WIDTH-1:0]           long_d,
  input  logic                            issue_valid,
  input  logic [ADDR_WIDTH-1:0]           issue_rw,
  input  logic [2*ADDR_WIDTH-1:0]         chk_rr,
  output logic                            stall,
  output logic                            drain_req,
  output logic                            wr,
  output logic                            jal,
  output logic [ADDR_WIDTH-1:0]           rw,
  output logic [DATA_WIDTH-1:0]           d,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] fifo_rw [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d  [FIFO_DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count, count_next;
  logic [REG_DEPTH-1:0]  pending, pending_next;
  logic [SW-1:0]         starve, starve_next;

  logic                  empty, push, pop;
  logic [ADDR_WIDTH-1:0] head_rw;
  logic                  sel_wr, sel_jal;
  logic [ADDR_WIDTH-1:0] sel_rw;
  logic [DATA_WIDTH-1:0] sel_d;

  assign empty      = (count == CW'(0));
  assign long_ready = (count < CW'(FIFO_DEPTH)) && !rst;
  assign push       = long_valid && long_ready;
  assign pop        = !pipe_valid && !empty && !rst;
  assign head_rw    = fifo_rw[rptr];
  assign fifo_count = count;
  assign stall      = pending[chk_rr[ADDR_WIDTH-1:0]] | pending[chk_rr[2*ADDR_WIDTH-1:ADDR_WIDTH]];

  always_comb begin
    sel_wr       = 1'b0;
    sel_jal      = 1'b0;
    sel_rw       = '0;
    sel_d        = '0;
    starve_next  = starve;
    pending_next = pending;
    count_next   = count;
    if (pipe_valid) begin
      sel_jal = pipe_jal;
      sel_rw  = pipe_jal ? ADDR_WIDTH'(REG_DEPTH - 1) : pipe_rw;
      sel_d   = pipe_d;
      sel_wr  = (sel_rw != '0);
    end else if (!empty) begin
      sel_rw = head_rw;
      sel_d  = fifo_d[rptr];
      sel_wr = (head_rw != '0);
    end else begin
      sel_wr = 1'b0;
    end
    // Starvation only accumulates while the head is blocked by pipeline traffic.
    if (empty || pop) begin
      starve_next = '0;
    end else if (pipe_valid && (starve < SW'(STARVE_LIMIT))) begin
      starve_next = starve + SW'(1);
    end else begin
      starve_next = starve;
    end
    // Clear before set so a same-cycle issue to the popped register wins.
    if (pop) begin
      pending_next[head_rw] = 1'b0;
    end else begin
      pending_next = pending_next;
    end
    if (issue_valid) begin
      pending_next[issue_rw] = 1'b1;
    end else begin
      pending_next = pending_next;
    end
    pending_next[0] = 1'b0;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr        <= 1'b0;
      jal       <= 1'b0;
      rw        <= '0;
      d         <= '0;
      drain_req <= 1'b0;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      pending   <= '0;
      starve    <= '0;
    end else begin
      wr        <= sel_wr;
      jal       <= sel_jal;
      rw        <= sel_rw;
      d         <= sel_d;
      drain_req <= (starve_next >= SW'(STARVE_LIMIT));
      count     <= count_next;
      pending   <= pending_next;
      starve    <= starve_next;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rw[wptr] <= long_rw;
      fifo_d[wptr]  <= long_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst, pipe_valid, pipe_jal, long_valid, issue_valid;
  logic [4:0]  pipe_rw, long_rw, issue_rw;
  logic [31:0] pipe_d, long_d;
  logic [9:0]  chk_rr;
  logic        long_ready, stall, drain_req, wr, jal;
  logic [4:0]  rw;
  logic [31:0] d;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .pipe_valid(pipe_valid), .pipe_jal(pipe_jal),
    .pipe_rw(pipe_rw), .pipe_d(pipe_d), .long_valid(long_valid),
    .long_ready(long_ready), .long_rw(long_rw), .long_d(long_d),
    .issue_valid(issue_valid), .issue_rw(issue_rw), .chk_rr(chk_rr),
    .stall(stall), .drain_req(drain_req), .wr(wr), .jal(jal), .rw(rw),
    .d(d), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rw;
    logic [31:0] d;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  logic [31:0] pend;
  int          starve;
  bit          model_ok = 1'b0;
  bit          e_sel;
  logic        e_wr, e_jal, e_drain;
  logic [4:0]  e_rw;
  logic [31:0] e_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance on each rising edge from the sampled inputs
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      pend = 32'd0; starve = 0; model_ok = 1'b1;
      e_sel = 1'b0; e_wr = 1'b0; e_jal = 1'b0; e_drain = 1'b0;
      e_rw = 5'd0; e_d = 32'd0;
    end else if (model_ok) begin
      bit was_empty, do_push, do_pop;
      ent_t h;
      was_empty = (q.size() == 0);
      do_pop    = !pipe_valid && !was_empty;
      do_push   = long_valid && (q.size() < 4);
      e_sel = 1'b1; e_jal = 1'b0;
      if (pipe_valid) begin
        e_jal = pipe_jal;
        e_rw  = pipe_jal ? 5'd31 : pipe_rw;
        e_d   = pipe_d;
        e_wr  = (e_rw != 5'd0);
      end else if (do_pop) begin
        h = q.pop_front();
        e_rw = h.rw; e_d = h.d; e_wr = (h.rw != 5'd0);
        pend[h.rw] = 1'b0;
      end else begin
        e_sel = 1'b0; e_wr = 1'b0;
      end
      if (was_empty || do_pop) starve = 0;
      else if (pipe_valid && starve < 8) starve = starve + 1;
      e_drain = (starve >= 8);
      if (issue_valid && issue_rw != 5'd0) pend[issue_rw] = 1'b1;
      if (do_push) q.push_back('{rw: long_rw, d: long_d});
    end
  end

  // Compare process: every falling edge once the model is initialised
  always @(negedge clk) begin
    if (model_ok) begin
      chk("long_ready", {63'd0, long_ready}, {63'd0, (!rst && q.size() < 4)});
      chk("stall", {63'd0, stall}, {63'd0, (pend[chk_rr[4:0]] | pend[chk_rr[9:5]])});
      chk("wr", {63'd0, wr}, {63'd0, e_wr});
      chk("jal", {63'd0, jal}, {63'd0, e_jal});
      chk("drain_req", {63'd0, drain_req}, {63'd0, e_drain});
      chk("fifo_count", {61'd0, fifo_count}, 64'(q.size()));
      if (e_sel) begin
        chk("rw", {59'd0, rw}, {59'd0, e_rw});
        chk("d", {32'd0, d}, {32'd0, e_d});
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0; pipe_jal = 1'b0; pipe_rw = 5'd0; pipe_d = 32'd0;
    long_valid = 1'b0; long_rw = 5'd0; long_d = 32'd0;
    issue_valid = 1'b0; issue_rw = 5'd0;
  endtask

  initial begin
    rst = 1'b1; chk_rr = 10'd0;
    idle_inputs();
    // Reset then idle
    cyc(); cyc();
    chk("rst_wr", {63'd0, wr}, 64'd0);
    chk("rst_long_ready", {63'd0, long_ready}, 64'd0);
    rst = 1'b0;
    cyc();
    chk("idle_long_ready", {63'd0, long_ready}, 64'd1);
    chk("idle_count", {61'd0, fifo_count}, 64'd0);
    chk("idle_drain", {63'd0, drain_req}, 64'd0);

    // Pipeline JAL
    pipe_valid = 1'b1; pipe_jal = 1'b1; pipe_rw = 5'd7; pipe_d = 32'h0040_0010;
    cyc();
    idle_inputs();
    chk("jal_wr", {63'd0, wr}, 64'd1);
    chk("jal_jal", {63'd0, jal}, 64'd1);
    chk("jal_rw", {59'd0, rw}, 64'd31);
    chk("jal_d", {32'd0, d}, 64'h0040_0010);

    // Scoreboard lifecycle
    issue_valid = 1'b1; issue_rw = 5'd5; chk_rr = {5'd5, 5'd3};
    cyc();
    issue_valid = 1'b0;
    chk("sb_stall_set", {63'd0, stall}, 64'd1);
    cyc(); cyc();
    long_valid = 1'b1; long_rw = 5'd5; long_d = 32'h0000_DEAD;
    cyc();
    long_valid = 1'b0;
    chk("sb_stall_hold", {63'd0, stall}, 64'd1);
    cyc();
    chk("sb_wr", {63'd0, wr}, 64'd1);
    chk("sb_rw", {59'd0, rw}, 64'd5);
    chk("sb_d", {32'd0, d}, 64'h0000_DEAD);
    chk("sb_stall_clr", {63'd0, stall}, 64'd0);

    // Priority, full FIFO and starvation
    pipe_valid = 1'b1; pipe_rw = 5'd1; pipe_d = 32'h1111;
    long_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      long_rw = 5'(10 + i); long_d = 32'(100 + i);
      if (i == 4) begin
        chk("full_ready", {63'd0, long_ready}, 64'd0);
        chk("full_count", {61'd0, fifo_count}, 64'd4);
      end
      cyc();
    end
    chk("prio_rw", {59'd0, rw}, 64'd1);
    cyc(); cyc(); cyc();
    chk("starve_pre", {63'd0, drain_req}, 64'd0);
    cyc();
    chk("starve_req", {63'd0, drain_req}, 64'd1);
    pipe_valid = 1'b0; long_valid = 1'b0;
    cyc();
    chk("drain_wr", {63'd0, wr}, 64'd1);
    chk("drain_rw", {59'd0, rw}, 64'd10);
    chk("drain_d", {32'd0, d}, 64'd100);
    chk("drain_req_clr", {63'd0, drain_req}, 64'd0);
    chk("drain_count", {61'd0, fifo_count}, 64'd3);
    cyc(); cyc(); cyc();
    idle_inputs();

    // Issue to register 0 never pends
    issue_valid = 1'b1; issue_rw = 5'd0; chk_rr = 10'd0;
    cyc();
    issue_valid = 1'b0;
    chk("r0_stall", {63'd0, stall}, 64'd0);

    // Destination-0 FIFO entry is popped without a write
    long_valid = 1'b1; long_rw = 5'd0; long_d = 32'd5;
    cyc();
    long_valid = 1'b0;
    cyc();
    chk("d0_wr", {63'd0, wr}, 64'd0);
    chk("d0_d", {32'd0, d}, 64'd5);
    chk("d0_count", {61'd0, fifo_count}, 64'd0);

    // Same-cycle set and clear of register 9
    issue_valid = 1'b1; issue_rw = 5'd9; chk_rr = {5'd9, 5'd9};
    cyc();
    issue_valid = 1'b0; long_valid = 1'b1; long_rw = 5'd9; long_d = 32'h99;
    cyc();
    long_valid = 1'b0; issue_valid = 1'b1; issue_rw = 5'd9;
    cyc();
    issue_valid = 1'b0;
    chk("set_wins_wr", {63'd0, wr}, 64'd1);
    chk("set_wins_rw", {59'd0, rw}, 64'd9);
    chk("set_wins_stall", {63'd0, stall}, 64'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      pipe_valid  = ($urandom_range(0, 9) < 5);
      pipe_jal    = ($urandom_range(0, 9) == 0);
      pipe_rw     = 5'($urandom);
      pipe_d      = $urandom;
      long_valid  = ($urandom_range(0, 9) < 4);
      long_rw     = 5'($urandom);
      long_d      = $urandom;
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_rw    = 5'($urandom);
      chk_rr      = 10'($urandom);
      cyc();
    end
    rst = 1'b0;
    idle_inputs();
    for (int n = 0; n < 8; n++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
